// File: rtl/display_scan_if.sv
// display_scan_if: memory read port, buffer-swap handshake and HUB75 panel pins of display_scan
interface display_scan_if #(
    parameter int rows = 8,
    parameter int columns = 32,
    parameter int bitdepth = 8
);
    localparam int rw = rows > 1 ? $clog2(rows) : 1;
    localparam int cw = columns > 1 ? $clog2(columns) : 1;
    logic                  swap;
    logic                  swap_done;
    logic                  flip;
    logic [rw-1:0]         rrow;
    logic [cw-1:0]         rcol;
    logic [3*bitdepth-1:0] rdata;
    logic                  panel_clk;
    logic                  panel_lat;
    logic                  panel_oe;
    logic [rw-1:0]         panel_addr;
    logic                  panel_r;
    logic                  panel_g;
    logic                  panel_b;
    modport master (
        input  swap, rdata,
        output swap_done, flip, rrow, rcol,
        output panel_clk, panel_lat, panel_oe, panel_addr, panel_r, panel_g, panel_b
    );
    modport slave (
        output swap, rdata,
        input  swap_done, flip, rrow, rcol,
        input  panel_clk, panel_lat, panel_oe, panel_addr, panel_r, panel_g, panel_b
    );
endinterface

// File: rtl/display_scan.sv
// display_scan: BCM scan-out of the displayed buffer to a HUB75 panel; DISPLAY_SCAN_DIM_EN adds a dim input that shortens the lit part of SHOW
module display_scan #(
    parameter int rows = 8,
    parameter int columns = 32,
    parameter int bitdepth = 8,
    parameter int show_base = 4
) (
    input logic clk,
    input logic rst,
`ifdef DISPLAY_SCAN_DIM_EN
    input logic [1:0] dim,
`endif
    display_scan_if.master bus
);
    localparam int cw = columns > 1 ? $clog2(columns) : 1;
    localparam int rw = rows > 1 ? $clog2(rows) : 1;
    localparam int pw = bitdepth > 1 ? $clog2(bitdepth) : 1;
    localparam int shift_end = 2 * columns;
    localparam int show_max = show_base << (bitdepth - 1);
    localparam int nw = $clog2((shift_end > show_max ? shift_end : show_max) + 1);
    localparam logic [1:0] st_shift = 2'd0;
    localparam logic [1:0] st_blank = 2'd1;
    localparam logic [1:0] st_latch = 2'd2;
    localparam logic [1:0] st_show  = 2'd3;

    logic [1:0]          state;
    logic [nw-1:0]       cnt;
    logic [pw-1:0]       plane;
    logic                pending;
    logic [31:0]         show_len;
    logic                show_last;
    logic                plane_last;
    logic                frame_end;
    logic                do_swap;
    logic [bitdepth-1:0] red;
    logic [bitdepth-1:0] grn;
    logic [bitdepth-1:0] blu;

    assign red = bus.rdata[3*bitdepth-1:2*bitdepth];
    assign grn = bus.rdata[2*bitdepth-1:bitdepth];
    assign blu = bus.rdata[bitdepth-1:0];
    assign show_len = 32'(show_base) << plane;
    assign show_last = state == st_show && 32'(cnt) == show_len - 32'd1;
    assign plane_last = 32'(plane) == 32'(bitdepth - 1);
    assign frame_end = show_last && plane_last && 32'(bus.rrow) == 32'(rows - 1);
    assign do_swap = frame_end && (pending || bus.swap);

    // Odd SHIFT cycles load data with the clock low, even ones raise it, so data is always set up a cycle ahead
    assign bus.panel_clk = state == st_shift && cnt != '0 && !cnt[0];
    assign bus.panel_lat = state == st_latch;
`ifdef DISPLAY_SCAN_DIM_EN
    assign bus.panel_oe = !(state == st_show && 32'(cnt) < (show_len >> dim));
`else
    assign bus.panel_oe = state != st_show;
`endif

    // Phase sequencer: cnt times each phase, plane steps after every SHOW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_shift;
            cnt   <= '0;
            plane <= '0;
        end else begin
            case (state)
                st_shift: begin
                    state <= 32'(cnt) == 32'(shift_end) ? st_blank : st_shift;
                    cnt   <= 32'(cnt) == 32'(shift_end) ? '0 : cnt + nw'(1);
                end
                st_blank: state <= st_latch;
                st_latch: begin
                    state <= st_show;
                    cnt   <= '0;
                end
                default: begin
                    state <= show_last ? st_shift : st_show;
                    cnt   <= show_last ? '0 : cnt + nw'(1);
                    plane <= show_last ? (plane_last ? '0 : plane + pw'(1)) : plane;
                end
            endcase
        end
    end

    // Column fetch: rdata for column c arrives on odd cycle 2c+1, captured as the address moves on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rcol    <= '0;
            bus.panel_r <= 1'b0;
            bus.panel_g <= 1'b0;
            bus.panel_b <= 1'b0;
        end else if (state == st_shift && cnt[0]) begin
            bus.rcol    <= 32'(bus.rcol) == 32'(columns - 1) ? '0 : bus.rcol + cw'(1);
            bus.panel_r <= red[plane];
            bus.panel_g <= grn[plane];
            bus.panel_b <= blu[plane];
        end
    end

    // Row address steps after the last plane; the panel row follows it on entry to LATCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rrow       <= '0;
            bus.panel_addr <= '0;
        end else begin
            if (state == st_blank)
                bus.panel_addr <= bus.rrow;
            if (show_last && plane_last)
                bus.rrow <= 32'(bus.rrow) == 32'(rows - 1) ? '0 : bus.rrow + rw'(1);
        end
    end

    // Swap requests are remembered until the frame boundary, the only point where flip may change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.flip      <= 1'b0;
            bus.swap_done <= 1'b0;
            pending       <= 1'b0;
        end else begin
            bus.flip      <= bus.flip ^ do_swap;
            bus.swap_done <= do_swap;
            pending       <= !frame_end && (pending || bus.swap);
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: randomized self-checking bench for display_scan against a cycle-position reference model
module tb_display_scan;
    localparam int rows = 2;
    localparam int cols = 4;
    localparam int bd = 2;
    localparam int sb = 2;
    localparam int w = 3 * bd;
    localparam int rw = 1;
    localparam int frame = 56;

    typedef struct packed {
        logic pclk, lat, oe, rise, r, g, b;
        logic [rw-1:0] row, addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] dim = 2'd0;
    logic [w-1:0] mem [rows][cols];
    int srow, scol;
    int checks = 0;
    int errors = 0;

    display_scan_if #(.rows(rows), .columns(cols), .bitdepth(bd)) bus ();

    display_scan #(.rows(rows), .columns(cols), .bitdepth(bd), .show_base(sb)) dut (
        .clk(clk),
        .rst(rst),
`ifdef DISPLAY_SCAN_DIM_EN
        .dim(dim),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Expected outputs at cycle t after reset release, from the plane/row/frame layout
    function automatic exp_t model(int t);
        exp_t e;
        int o, p, row, s, lat_o;
        logic [w-1:0] d, sh;
        o = t % frame;
        p = 0;
        row = 0;
        while (o >= 3 + 2 * cols + (sb << p)) begin
            o -= 3 + 2 * cols + (sb << p);
            p++;
            if (p == bd) begin
                p = 0;
                row++;
            end
        end
        lat_o = 2 * cols + 2;
        s = o - (2 * cols + 3);
        e.pclk = o >= 1 && o <= 2 * cols && o % 2 == 0;
        e.lat = o == lat_o;
        e.oe = !(s >= 0 && s < ((sb << p) >> dim));
        e.rise = e.pclk;
        d = '0;
        if (e.rise) d = mem[row][(o - 2) / 2];
        sh = d >> (2 * bd + p);
        e.r = sh[0];
        sh = d >> (bd + p);
        e.g = sh[0];
        sh = d >> p;
        e.b = sh[0];
        e.row = rw'(row);
        e.addr = rw'((o >= lat_o || p > 0) ? row : (t < lat_o ? 0 : (row + rows - 1) % rows));
        return e;
    endfunction

    function automatic int oe_low_per_frame();
        int n = 0;
        for (int p = 0; p < bd; p++) n += (sb << p) >> dim;
        return n * rows;
    endfunction

    // One clock: registered memory returns the word addressed during the previous cycle
    task automatic step();
        @(negedge clk);
        bus.rdata = mem[srow][scol];
        srow = int'(bus.rrow);
        scol = int'(bus.rcol);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.swap = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        srow = 0;
        scol = 0;
        bus.rdata = '0;
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                mem[r][c] = mode == 0 ? w'(6'b111111) : mode == 1 ? (c == 0 ? w'(6'b100000) : '0) : w'($urandom);
    endtask

    task automatic test_reset();
        bus.swap = 1'b0;
        bus.rdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.panel_clk, bus.panel_lat, bus.panel_oe} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 001", {bus.panel_clk, bus.panel_lat, bus.panel_oe});
        end
        checks++;
        if ({bus.flip, bus.swap_done, bus.panel_r, bus.panel_g, bus.panel_b} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {bus.flip, bus.swap_done, bus.panel_r, bus.panel_g, bus.panel_b});
        end
        checks++;
        if (bus.rrow !== '0 || bus.rcol !== '0 || bus.panel_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr got rrow=%0d rcol=%0d addr=%0d want 0", bus.rrow, bus.rcol, bus.panel_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_scan(input int mode, input string name);
        exp_t e;
        int low = 0;
        fill(mode);
        do_reset();
        for (int t = 0; t < 2 * frame; t++) begin
            e = model(t);
            checks++;
            if ({bus.panel_clk, bus.panel_lat, bus.panel_oe} !== {e.pclk, e.lat, e.oe}) begin
                errors++;
                $display("FAIL %s ctrl t=%0d got clk/lat/oe=%b want %b", name, t, {bus.panel_clk, bus.panel_lat, bus.panel_oe}, {e.pclk, e.lat, e.oe});
            end
            checks++;
            if (bus.rrow !== e.row || bus.panel_addr !== e.addr) begin
                errors++;
                $display("FAIL %s row t=%0d got rrow=%0d addr=%0d want %0d %0d", name, t, bus.rrow, bus.panel_addr, e.row, e.addr);
            end
            checks++;
            if (bus.flip !== 1'b0 || bus.swap_done !== 1'b0) begin
                errors++;
                $display("FAIL %s flip t=%0d got flip=%b done=%b want 0 0", name, t, bus.flip, bus.swap_done);
            end
            if (e.rise) begin
                checks++;
                if ({bus.panel_r, bus.panel_g, bus.panel_b} !== {e.r, e.g, e.b}) begin
                    errors++;
                    $display("FAIL %s rgb t=%0d got %b want %b", name, t, {bus.panel_r, bus.panel_g, bus.panel_b}, {e.r, e.g, e.b});
                end
            end
            if (t < frame && bus.panel_oe === 1'b0) low++;
            step();
        end
        checks++;
        if (low != oe_low_per_frame()) begin
            errors++;
            $display("FAIL %s oe_low_count got %0d want %0d", name, low, oe_low_per_frame());
        end
    endtask

    task automatic test_swap(input int mode, input string name);
        exp_t e;
        logic eflip = 1'b0;
        logic edone, seen = 1'b0, sw;
        fill(2);
        do_reset();
        for (int t = 0; t < 3 * frame + 2; t++) begin
            e = model(t);
            edone = 1'b0;
            if (t > 0 && t % frame == 0) begin
                edone = seen;
                eflip ^= seen;
                seen = 1'b0;
            end
            checks++;
            if (bus.flip !== eflip || bus.swap_done !== edone) begin
                errors++;
                $display("FAIL %s t=%0d got flip=%b done=%b want %b %b", name, t, bus.flip, bus.swap_done, eflip, edone);
            end
            checks++;
            if (bus.rrow !== e.row) begin
                errors++;
                $display("FAIL %s rrow t=%0d got %0d want %0d", name, t, bus.rrow, e.row);
            end
            sw = mode == 1 ? t == 20 : mode == 2 ? t < 112 : $urandom_range(0, 39) == 0;
            bus.swap = sw;
            seen |= sw;
            step();
        end
        bus.swap = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        fill(2);
        do_reset();
        for (int t = 0; t < 109; t++) begin
            bus.swap = t == 20;
            step();
        end
        bus.swap = 1'b0;
        checks++;
        if (bus.flip !== 1'b1 || bus.panel_oe !== 1'b0 || bus.rrow !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got flip=%b oe=%b rrow=%0d want 1 0 1", bus.flip, bus.panel_oe, bus.rrow);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.panel_oe !== 1'b1 || bus.rrow !== '0 || bus.flip !== 1'b0 || bus.swap_done !== 1'b0 || bus.panel_clk !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got oe=%b rrow=%0d flip=%b done=%b clk=%b want 1 0 0 0 0", bus.panel_oe, bus.rrow, bus.flip, bus.swap_done, bus.panel_clk);
        end
        @(negedge clk);
        rst = 1'b0;
        srow = 0;
        scol = 0;
        bus.rdata = '0;
        for (int t = 0; t < frame + 1; t++) begin
            e = model(t);
            checks++;
            if ({bus.panel_clk, bus.panel_lat, bus.panel_oe, bus.rrow, bus.flip} !== {e.pclk, e.lat, e.oe, e.row, 1'b0}) begin
                errors++;
                $display("FAIL mid_restart t=%0d got %b want %b", t, {bus.panel_clk, bus.panel_lat, bus.panel_oe, bus.rrow, bus.flip}, {e.pclk, e.lat, e.oe, e.row, 1'b0});
            end
            if (e.rise) begin
                checks++;
                if ({bus.panel_r, bus.panel_g, bus.panel_b} !== {e.r, e.g, e.b}) begin
                    errors++;
                    $display("FAIL mid_restart_rgb t=%0d got %b want %b", t, {bus.panel_r, bus.panel_g, bus.panel_b}, {e.r, e.g, e.b});
                end
            end
            step();
        end
    endtask

`ifdef DISPLAY_SCAN_DIM_EN
    task automatic test_dim(input logic [1:0] dv);
        exp_t e;
        int low = 0;
        dim = dv;
        fill(2);
        do_reset();
        for (int t = 0; t < frame + 2; t++) begin
            e = model(t);
            checks++;
            if ({bus.panel_oe, bus.panel_lat, bus.panel_clk, bus.rrow} !== {e.oe, e.lat, e.pclk, e.row}) begin
                errors++;
                $display("FAIL dim%0d t=%0d got oe/lat/clk/row=%b want %b", dv, t, {bus.panel_oe, bus.panel_lat, bus.panel_clk, bus.rrow}, {e.oe, e.lat, e.pclk, e.row});
            end
            if (t < frame && bus.panel_oe === 1'b0) low++;
            step();
        end
        checks++;
        if (low != oe_low_per_frame()) begin
            errors++;
            $display("FAIL dim%0d oe_low_count got %0d want %0d", dv, low, oe_low_per_frame());
        end
        dim = 2'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_scan(0, "all_ones");
        test_scan(1, "col0_red");
        test_scan(2, "random_a");
        test_scan(2, "random_b");
        test_swap(1, "swap_pulse");
        test_swap(2, "swap_held");
        test_swap(3, "swap_random");
        test_reset_mid();
`ifdef DISPLAY_SCAN_DIM_EN
        test_dim(2'd1);
        test_dim(2'd3);
        test_dim(2'($urandom_range(0, 3)));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_scan.md
# display_scan

Scan-out reader for the double-buffered display memory. It walks every row and column of the displayed buffer through the memory's registered read port. It serializes binary-coded-modulation (BCM) bit planes onto a HUB75-style LED panel (clock, latch, blank, row address, one RGB lane). It owns the `flip` select, toggling it only at frame boundaries on request from the frame writer.

## Interface
Parameters:
- `rows`, 8, panel rows per scan (row address width `$clog2(rows)`)
- `columns`, 32, pixels shifted per row
- `bitdepth`, 8, bits per colour channel; pixel word width is `3*bitdepth`
- `show_base`, 4, display cycles for bit plane 0; plane b shows `show_base << b` cycles

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `swap`  in  1  frame writer requests buffer exchange
- `swap_done`  out  1  one-cycle pulse when `flip` has toggled
- `flip`  out  1  displayed-buffer select to memory
- `rrow`  out  `$clog2(rows)`  read row address
- `rcol`  out  `$clog2(columns)`  read column address
- `rdata`  in  `3*bitdepth`  read data, valid one cycle after `rrow`/`rcol`
- `panel_clk`  out  1  shift clock; data sampled on rising edge
- `panel_lat`  out  1  latch strobe, active high
- `panel_oe`  out  1  output enable, active low (1 = blank)
- `panel_addr`  out  `$clog2(rows)`  displayed row
- `panel_r`, `panel_g`, `panel_b`  out  1 each  serial colour bits

## Operation
- Channel slices: red `rdata[3*bitdepth-1:2*bitdepth]`, green `[2*bitdepth-1:bitdepth]`, blue `[bitdepth-1:0]`. Plane b drives bit b of each channel.
- FSM: SHIFT -> BLANK -> LATCH -> SHOW -> (next plane, or next row at plane 0) -> SHIFT.
- SHIFT lasts `1 + 2*columns` cycles. Cycle 0 presents `rcol=0` (prefetch).
  - Cycle 2c+1: registers bits of column c from `rdata`, drives `panel_clk=0`, advances `rcol` to c+1.
  - Cycle 2c+2: drives `panel_clk=1` with data held.
  - `rcol` wraps to 0 after the last column.
- BLANK (1 cycle): `panel_oe=1`, `panel_clk=0`.
- LATCH (1 cycle): `panel_lat=1`, `panel_oe=1`, and `panel_addr` loads the current `rrow`.
- SHOW (`show_base << b` cycles): `panel_oe=0`. The last cycle advances the plane. After plane `bitdepth-1`, it advances `rrow`, wrapping at `rows-1` to 0.
- `panel_oe` is 1 in every state except SHOW.
- Swap:
  - A `swap` high on any cycle sets a sticky pending flag.
  - Frame end is the last SHOW cycle of plane `bitdepth-1`, row `rows-1`. On that cycle, if pending is set or `swap` is high, `flip` toggles on the next edge, `swap_done` pulses for that same next cycle, and pending clears.
  - `flip` never changes mid-frame.
- Reset (asynchronous, any state): `rrow=0`, `rcol=0`, `flip=0`, `swap_done=0`, `panel_clk=0`, `panel_lat=0`, `panel_oe=1`, `panel_addr=0`, RGB=0, pending cleared, FSM at SHIFT cycle 0 of row 0 plane 0. Scanning starts on the first edge after release.

## Timing
- Memory read latency is exactly 1 cycle. The block never reads the same column twice per plane.
- Plane length is `3 + 2*columns + (show_base << b)` cycles. The frame is `rows` times the sum over planes.
- Example: rows=2, columns=4, bitdepth=2, show_base=2 gives planes of 13 and 15 cycles, rows of 28 cycles, and frames of 56 cycles.
- `swap_done` asserts one cycle after the frame-end SHOW cycle, coincident with the new `flip` and the first SHIFT cycle of the next frame.
- `rrow` is stable for a whole row. `panel_addr` changes only in LATCH.

## Configuration
- `DISPLAY_SCAN_DIM_EN`: when defined, the block adds input port `dim` (2 bits).
  - In SHOW, `panel_oe=0` only for the first `(show_base << b) >> dim` cycles and 1 for the rest. If that count is 0, the plane stays blank.
  - SHOW duration and all other timing are unchanged.
- Undefined: no `dim` port, and `panel_oe=0` for all of SHOW.

## Test plan
Use rows=2, columns=4, bitdepth=2, show_base=2 throughout.
- Reset, then all `rdata=6'b111111` -> 4 `panel_clk` rising edges per SHIFT with R=G=B=1. Latch pulse lands at cycle 10 of each plane. SHOW lasts 2 then 4 cycles. Frame is 56 cycles.
- `rdata` depends on `rcol` (col0=`6'b100000`, others 0) -> R=1 only on the first rising edge of plane 1, never in plane 0. G and B stay 0.
- `swap` pulsed at cycle 20 -> no `flip` change until cycle 56, then `flip=1` and a single `swap_done` pulse at cycle 56.
- `swap` held high across two frames -> `flip` toggles at cycles 56 and 112, with one `swap_done` each.
- `rst` asserted mid-SHOW of row 1 -> same cycle: `panel_oe=1`, `rrow=0`, `flip` returns to 0, no `swap_done`. The scan restarts cleanly from row 0.
- With `DISPLAY_SCAN_DIM_EN`, `dim=1` -> `panel_oe=0` for 1 cycle in plane 0 and 2 cycles in plane 1, and frame length stays 56. With `dim=3`, `panel_oe` never goes low.
